pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central pipeline stall controller for the 6-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Merges per-stage stall requests from IF, ID and MEM under a deepest-stage-wins priority.
- Sequences multi-cycle EX operations with a countdown FSM, so EX-side units declare a latency instead of holding a level request.
- The output stall[5:0] drives the id_ex bubble-insertion logic and all other stage registers.

Parameters:
- STALL_W, 6, stall vector width; bit 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- CNT_W, 6, width of the multi-cycle latency field and countdown counter.
- PERF_W, 32, width of the performance counters (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (rst == `RstEnable)
- stallreq_from_if  in  1  fetch not ready (instruction memory wait)
- stallreq_from_id  in  1  load-use hazard detected in decode
- stallreq_from_mem  in  1  data memory wait
- ex_mc_start  in  1  one-cycle pulse: EX begins a multi-cycle op
- ex_mc_cycles  in  CNT_W  total EX occupancy N in cycles, sampled with ex_mc_start
- stall  out  STALL_W  stall vector, `Stop = 1
- ex_mc_busy  out  1  high in the start cycle and in every BUSY-state cycle
- ex_mc_done  out  1  one-cycle pulse: the EX result is final and the instruction advances
- perf_stall_cycles  out  PERF_W  only with the feature
- perf_mc_ops  out  PERF_W  only with the feature

Behaviour:
- FSM states: IDLE, BUSY, DONE. The state register and a CNT_W-bit counter are the only sequential state besides the performance counters.
- Reset: on a rst-high clock edge, the state goes to IDLE, the counter to 0 and the performance counters to 0.
- While rst is high: stall=0, ex_mc_busy=0, ex_mc_done=0, all asserted combinationally regardless of inputs.
- An active multi-cycle op is discarded when reset occurs mid-operation; no done pulse is issued.
- IDLE:
  - ex_mc_start=1 with N>=2: counter<=N-1, go to BUSY.
  - ex_mc_start=1 with N=1: go to DONE.
  - N=0: the start is ignored; stay in IDLE with no EX stall.
- BUSY: if counter==1, go to DONE; otherwise counter<=counter-1.
- DONE: ex_mc_done=1 for exactly one cycle, then go to IDLE.
- ex_mc_start is ignored in BUSY and DONE. A DONE cycle followed by a start in the next IDLE cycle is legal (back-to-back ops).
- Timing: with a start at cycle T, the EX stall is asserted in cycles T..T+N-1 and ex_mc_done=1 at T+N. No stall from the EX source is asserted at T+N.
- The EX stall source is (IDLE & ex_mc_start & N!=0) | BUSY. It is purely combinational from state and inputs, with zero latency.
- Stall vector priority, first match wins:
  - mem request: 011111
  - EX source: 001111
  - id request: 000111
  - if request: 000011
  - none: 000000
- The countdown continues while a deeper MEM stall is active. The EX op keeps executing, and DONE may coincide with a MEM stall; in that case the stall vector is 011111 and ex_mc_done still pulses.
- Simultaneous requests are fully covered by the priority order; there are no other arbitration rules.
- The stall vector is always of the form 0…01…1. id_ex inserts a bubble whenever stall[2]=1 and stall[3]=0.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined:
  - perf_stall_cycles increments each non-reset cycle in which stall!=0.
  - perf_mc_ops increments on each DONE cycle.
  - Both wrap modulo 2^PERF_W.
- Undefined: both ports are still present and tied to 0, and no counter flops are built.

Decomposition:
- The shared defines header holds:
  - the stall bit indices (STALL_PC..STALL_WB);
  - the four stall pattern constants;
  - the state encodings (2-bit: IDLE=0, BUSY=1, DONE=2);
  - the existing `Stop, `NoStop and `RstEnable.
- One natural sub-module: mc_sequencer, containing the FSM, counter, ex_mc_busy and ex_mc_done. The top level contains only the priority encoder and the performance counters.

Test Plan:
- Reset with all requests high → stall=000000, busy=0, done=0; after release with no requests → 000000.
- stallreq_from_id=1 for 2 cycles alone → stall=000111 in exactly those cycles; with stallreq_from_mem also high → 011111.
- ex_mc_start with N=5 at T → stall=001111 for T..T+4, ex_mc_done=1 only at T+5, stall=000000 at T+5.
- N=1 → stall only at T, done at T+1. N=0 → no stall, no done. A second start at T+2 during N=5 → ignored, done still at T+5.
- N=4 at T with stallreq_from_mem high T+1..T+6 → stall=011111 for T+1..T+6, done still at T+4. Assert rst at T+2 of a new N=8 op → IDLE next cycle, no done pulse.
- With PIPE_STALL_PERF_EN, run two ops N=3 and N=2 → perf_mc_ops=2, perf_stall_cycles=5. Without the macro → both outputs read 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall bit indices, stall
// patterns, EX multi-cycle FSM encoding and the legacy stall/reset level macros.
`ifndef PIPE_STALL_CTRL_DEFINES
`define PIPE_STALL_CTRL_DEFINES
`define RstEnable 1'b1
`define Stop      1'b1
`define NoStop    1'b0
`endif

package pipe_stall_ctrl_pkg;

  localparam int STALL_W_DEF = 6;
  localparam int CNT_W_DEF   = 6;
  localparam int PERF_W_DEF  = 32;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Mask with every stage from PC up to and including stage idx stopped.
  function automatic logic [STALL_W_DEF-1:0] stall_upto(input int idx);
    logic [STALL_W_DEF-1:0] m;
    m = '0;
    for (int i = STALL_PC; i <= STALL_WB; i++) begin
      if (i <= idx) m[i] = `Stop;
    end
    return m;
  endfunction

  localparam logic [STALL_W_DEF-1:0] STALL_PAT_MEM  = stall_upto(STALL_MEM);
  localparam logic [STALL_W_DEF-1:0] STALL_PAT_EX   = stall_upto(STALL_EX);
  localparam logic [STALL_W_DEF-1:0] STALL_PAT_ID   = stall_upto(STALL_ID);
  localparam logic [STALL_W_DEF-1:0] STALL_PAT_IF   = stall_upto(STALL_IF);
  localparam logic [STALL_W_DEF-1:0] STALL_PAT_NONE = '0;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_sequencer.sv
// Countdown sequencer for multi-cycle EX operations: an op of N cycles holds
// busy for N cycles starting with the start cycle, then pulses done once.
module mc_sequencer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done
);

  mc_state_e        state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (start && cycles >= CNT_W'(2)) begin
            cnt   <= cycles - CNT_W'(1);
            state <= MC_BUSY;
          end else if (start && cycles == CNT_W'(1)) begin
            state <= MC_DONE;
          end
        end
        MC_BUSY: begin
          if (cnt == CNT_W'(1)) state <= MC_DONE;
          else                  cnt   <= cnt - CNT_W'(1);
        end
        MC_DONE: state <= MC_IDLE;
        default: state <= MC_IDLE;
      endcase
    end
  end

  // Busy covers the start cycle itself so EX stalls with zero latency.
  assign busy = (rst != `RstEnable) &&
                ((state == MC_IDLE && start && cycles != '0) || state == MC_BUSY);
  assign done = (rst != `RstEnable) && (state == MC_DONE);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: deepest-stage-wins merge of IF/ID/MEM requests and
// the EX multi-cycle sequencer. Optional counters enabled by PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W = STALL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PERF_W  = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_mem,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  output logic [STALL_W-1:0] stall,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_mc_ops
);

  mc_sequencer #(.CNT_W(CNT_W)) u_mc_sequencer (
    .clk    (clk),
    .rst    (rst),
    .start  (ex_mc_start),
    .cycles (ex_mc_cycles),
    .busy   (ex_mc_busy),
    .done   (ex_mc_done)
  );

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    stall = {STALL_W{`NoStop}};
    if (rst == `RstEnable)  stall = {STALL_W{`NoStop}};
    else if (stallreq_from_mem) stall = STALL_W'(STALL_PAT_MEM);
    else if (ex_mc_busy)        stall = STALL_W'(STALL_PAT_EX);
    else if (stallreq_from_id)  stall = STALL_W'(STALL_PAT_ID);
    else if (stallreq_from_if)  stall = STALL_W'(STALL_PAT_IF);
  end

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      perf_stall_cycles <= '0;
      perf_mc_ops       <= '0;
    end else begin
      if (stall != '0) perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
      if (ex_mc_done)  perf_mc_ops       <= perf_mc_ops + PERF_W'(1);
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_mc_ops       = '0;
`endif

endmodule
